// File: rtl/hbm_edge_addr_gen.sv
// hbm_edge_addr_gen: turns edge ranges [loff, roff) into per-line HBM read addresses with edge masks.
// Optional statistics counters are enabled by defining HBM_EDGE_ADDR_GEN_STAT_EN.
module hbm_edge_addr_gen #(
  parameter int V_ID_WIDTH = 20,
  parameter int V_OFF_DWIDTH = 32,
  parameter int HBM_AWIDTH = 34,
  parameter int EDGE_PER_LINE = 16,
  parameter int LOG2_EPL = 4,
  parameter int LOG2_LINE_BYTES = 6,
  parameter logic [HBM_AWIDTH-1:0] EDGE_BASE_ADDR = '0,
  parameter int IN_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [V_ID_WIDTH-1:0]    front_active_v_id,
  input  logic [V_OFF_DWIDTH-1:0]  front_active_v_loff,
  input  logic [V_OFF_DWIDTH-1:0]  front_active_v_roff,
  input  logic                     front_active_v_valid,
  input  logic                     stage_full,
  output logic                     front_stage_full,
  output logic [HBM_AWIDTH-1:0]    rd_hbm_edge_addr,
  output logic                     rd_hbm_edge_valid,
  output logic [V_ID_WIDTH-1:0]    rd_hbm_edge_v_id,
  output logic [EDGE_PER_LINE-1:0] rd_hbm_edge_mask,
  output logic                     err_overflow,
  output logic [31:0]              stat_line_cnt,
  output logic [31:0]              stat_v_cnt
);
  localparam int LW = V_OFF_DWIDTH - LOG2_EPL;
  localparam int PW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CW = $clog2(IN_DEPTH + 1);
  typedef struct packed {
    logic [V_ID_WIDTH-1:0]   v_id;
    logic [V_OFF_DWIDTH-1:0] loff;
    logic [V_OFF_DWIDTH-1:0] roff;
  } req_t;
  typedef enum logic {IDLE, GEN} state_t;
  state_t state_q;
  req_t mem_q [IN_DEPTH];
  req_t head;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [V_ID_WIDTH-1:0] vid_q;
  logic [V_OFF_DWIDTH-1:0] loff_q, roff_q;
  logic [LW-1:0] cur_q, end_q;
  logic [EDGE_PER_LINE-1:0] mask_d;
  logic pop, push, issue;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(IN_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign head = mem_q[rd_ptr_q];
  assign pop = (state_q == IDLE) && (count_q != '0);
  assign push = front_active_v_valid && ((count_q != CW'(IN_DEPTH)) || pop);
  assign issue = (state_q == GEN) && !stage_full;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // one extra bit keeps roff near the top of the offset range from wrapping
  for (genvar j = 0; j < EDGE_PER_LINE; j++) begin : g_mask
    assign mask_d[j] = ({1'b0, cur_q, LOG2_EPL'(j)} >= {1'b0, loff_q}) &&
                       ({1'b0, cur_q, LOG2_EPL'(j)} <  {1'b0, roff_q});
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      vid_q <= '0;
      loff_q <= '0;
      roff_q <= '0;
      cur_q <= '0;
      end_q <= '0;
      front_stage_full <= 1'b0;
      err_overflow <= 1'b0;
      rd_hbm_edge_valid <= 1'b0;
      rd_hbm_edge_addr <= '0;
      rd_hbm_edge_v_id <= '0;
      rd_hbm_edge_mask <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{front_active_v_id, front_active_v_loff, front_active_v_roff};
        wr_ptr_q <= nxt(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= nxt(rd_ptr_q);
      count_q <= count_d;
      front_stage_full <= count_d >= CW'(IN_DEPTH - 1);
      err_overflow <= err_overflow | (front_active_v_valid & ~push);
      rd_hbm_edge_valid <= issue;
      if (state_q == IDLE) begin
        if (pop && head.roff > head.loff) begin
          state_q <= GEN;
          vid_q <= head.v_id;
          loff_q <= head.loff;
          roff_q <= head.roff;
          cur_q <= LW'(head.loff >> LOG2_EPL);
          end_q <= LW'((head.roff - V_OFF_DWIDTH'(1)) >> LOG2_EPL);
        end
      end else if (issue) begin
        rd_hbm_edge_addr <= EDGE_BASE_ADDR + (HBM_AWIDTH'(cur_q) << LOG2_LINE_BYTES);
        rd_hbm_edge_v_id <= vid_q;
        rd_hbm_edge_mask <= mask_d;
        cur_q <= cur_q + LW'(1);
        if (cur_q == end_q) state_q <= IDLE;
      end
    end
  end
`ifdef HBM_EDGE_ADDR_GEN_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_line_cnt <= '0;
      stat_v_cnt <= '0;
    end else begin
      if (issue && stat_line_cnt != '1) stat_line_cnt <= stat_line_cnt + 32'd1;
      if (issue && cur_q == end_q && stat_v_cnt != '1) stat_v_cnt <= stat_v_cnt + 32'd1;
    end
  end
`else
  assign stat_line_cnt = '0;
  assign stat_v_cnt = '0;
`endif
endmodule

// File: tb/tb_hbm_edge_addr_gen.sv
// tb_hbm_edge_addr_gen: directed and randomized checks of hbm_edge_addr_gen against a queue-based reference model.
module tb_hbm_edge_addr_gen;
  logic clk = 0;
  logic rst = 0;
  logic [19:0] v_id = '0;
  logic [31:0] loff = '0, roff = '0;
  logic valid = 0, stage_full = 0;
  logic fsf, out_valid, ovf;
  logic [33:0] out_addr;
  logic [19:0] out_vid;
  logic [15:0] out_mask;
  logic [31:0] stat_lines, stat_vs;
  int total = 0, bad = 0;

  hbm_edge_addr_gen dut (
    .clk(clk), .rst(rst),
    .front_active_v_id(v_id), .front_active_v_loff(loff), .front_active_v_roff(roff),
    .front_active_v_valid(valid), .stage_full(stage_full), .front_stage_full(fsf),
    .rd_hbm_edge_addr(out_addr), .rd_hbm_edge_valid(out_valid), .rd_hbm_edge_v_id(out_vid),
    .rd_hbm_edge_mask(out_mask), .err_overflow(ovf),
    .stat_line_cnt(stat_lines), .stat_v_cnt(stat_vs)
  );

  always #5 clk = ~clk;

  typedef struct { logic [19:0] vid; logic [31:0] lo; logic [31:0] hi; } req_t;
  typedef struct { logic [33:0] addr; logic [19:0] vid; logic [15:0] mask; bit last; } line_t;
  req_t fq[$];
  line_t pend[$];
  bit m_ovf, e_valid;
  logic [33:0] e_addr;
  logic [19:0] e_vid;
  logic [15:0] e_mask;
  longint m_lines, m_vs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // a range becomes the full list of lines it touches, each with its edge mask
  task automatic expand(input req_t r);
    longint first, last, e;
    line_t l;
    first = longint'(r.lo) / 16;
    last = (longint'(r.hi) - 1) / 16;
    for (longint ln = first; ln <= last; ln++) begin
      l.addr = 34'(ln * 64);
      l.vid = r.vid;
      l.last = (ln == last);
      for (int j = 0; j < 16; j++) begin
        e = ln * 16 + j;
        l.mask[j] = (e >= longint'(r.lo)) && (e < longint'(r.hi));
      end
      pend.push_back(l);
    end
  endtask

  task automatic model_step();
    req_t r;
    line_t l;
    if (!rst) begin
      fq.delete(); pend.delete();
      m_ovf = 0; e_valid = 0; e_addr = '0; e_vid = '0; e_mask = '0;
      m_lines = 0; m_vs = 0;
      return;
    end
    e_valid = 0;
    if (pend.size() == 0 && fq.size() != 0) begin
      r = fq.pop_front();
      if (r.hi > r.lo) expand(r);
    end else if (pend.size() != 0 && !stage_full) begin
      l = pend.pop_front();
      e_valid = 1; e_addr = l.addr; e_vid = l.vid; e_mask = l.mask;
      m_lines++;
      if (l.last) m_vs++;
    end
    if (valid) begin
      if (fq.size() == 4) m_ovf = 1;
      else begin
        r.vid = v_id; r.lo = loff; r.hi = roff;
        fq.push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", 64'(out_valid), 64'(e_valid));
    chk("addr", 64'(out_addr), 64'(e_addr));
    chk("v_id", 64'(out_vid), 64'(e_vid));
    chk("mask", 64'(out_mask), 64'(e_mask));
    chk("front_stage_full", 64'(fsf), 64'(fq.size() >= 3));
    chk("err_overflow", 64'(ovf), 64'(m_ovf));
`ifdef HBM_EDGE_ADDR_GEN_STAT_EN
    chk("stat_line_cnt", 64'(stat_lines), 64'(m_lines));
    chk("stat_v_cnt", 64'(stat_vs), 64'(m_vs));
`else
    chk("stat_line_cnt", 64'(stat_lines), 64'd0);
    chk("stat_v_cnt", 64'(stat_vs), 64'd0);
`endif
  endtask

  task automatic wr(input logic [19:0] id, input logic [31:0] lo, input logic [31:0] hi);
    v_id = id; loff = lo; roff = hi; valid = 1;
    tick();
    valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 0;
    idle(2);
    rst = 1;
    idle(1);
    wr(7, 0, 16); idle(4);
    wr(1, 5, 40); idle(6);
    wr(2, 100, 100); wr(3, 16, 17); idle(5);
    wr(4, 5, 40); idle(2);
    stage_full = 1; idle(3);
    stage_full = 0; idle(5);
    stage_full = 1;
    for (int i = 0; i < 6; i++) wr(20'(10 + i), 0, 16);
    idle(3);
    stage_full = 0; idle(12);
    wr(5, 5, 40); idle(2);
    rst = 0; idle(1);
    rst = 1; idle(3);
    wr(6, 0, 16); idle(4);
    wr(8, 32'hFFFF_FFE0, 32'hFFFF_FFFF); idle(5);
    for (int i = 0; i < 1500; i++) begin
      valid = ($urandom_range(0, 9) < 4);
      v_id = 20'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        loff = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        roff = 32'hFFFF_FFFF;
      end else begin
        loff = 32'($urandom_range(0, 200));
        roff = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 200)) : loff + 32'($urandom_range(0, 60));
      end
      stage_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end
    valid = 0; stage_full = 0; rst = 1;
    idle(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
